// File: rtl/cpu_bus_mem.sv
// ---------------------------------------------------------------------------
// cpu_bus_mem
//
// Clocked memory responder for the 6502 CPU bus. It holds a RAM/ROM array
// that is mirrored across the whole CPU address space, and it adds a fixed
// number of wait states per access by pulling rdy low. It also keeps
// statistics counters and a sticky protocol-error flag for scoreboarding.
//
// Parameters
//   ADDR_W      CPU address width
//   DATA_W      data width
//   MEM_AW      array index width (depth = 2**MEM_AW, mirrored)
//   WAIT_CYCLES rdy-low cycles inserted per access, legal range 0..15
//   ROM_START   first write-protected address (addr >= ROM_START is ROM)
//   CNT_W       statistics counter width (counters wrap, never saturate)
//
// Ports
//   clk          single clock, all state changes on its rising edge
//   rst          synchronous active-low reset
//   addr_out     CPU address
//   data_out     CPU write data
//   ren / wen    read / write request (both high = protocol error)
//   data_in      registered read data back to the CPU
//   rdy          bus ready, decoded from the FSM state; 0 stalls the CPU
//   rd_cnt       completed reads
//   wr_cnt       committed writes
//   wr_drop_cnt  writes discarded because they targeted ROM
//   err          sticky, set when ren and wen are sampled high together
// ---------------------------------------------------------------------------
module cpu_bus_mem #(
    parameter int                 ADDR_W      = 16,
    parameter int                 DATA_W      = 8,
    parameter int                 MEM_AW      = 11,
    parameter int                 WAIT_CYCLES = 0,
    parameter logic [ADDR_W-1:0]  ROM_START   = {ADDR_W{1'b1}},
    parameter int                 CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_out,
    input  logic [DATA_W-1:0] data_out,
    input  logic              ren,
    input  logic              wen,
    output logic [DATA_W-1:0] data_in,
    output logic              rdy,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic [CNT_W-1:0]  wr_drop_cnt,
    output logic              err
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Value loaded into the wait counter when an access is accepted. The
    // guard keeps the constant non-negative for the zero-wait build, where
    // it is never used.
    localparam int WAIT_M1 = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

    // NOTE: the array has no reset; its contents survive rst and are
    // preloaded by the bench, which also lets it map onto plain RAM.
    logic [DATA_W-1:0] mem [2**MEM_AW];

    state_t            state;
    logic [3:0]        cnt;

    // Request captured when it is accepted, replayed on the commit edge.
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_data;
    logic              lat_write;

    // Access performed on the coming edge, whichever path it came from.
    logic              acc_fire;
    logic              acc_write;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_data;
    logic [MEM_AW-1:0] acc_idx;
    logic              acc_in_rom;
    logic              mem_we;

    logic              req_valid;
    logic              req_conflict;

    // Requests are only looked at in IDLE; in WAIT the bus is ignored.
    assign req_valid    = (state == IDLE) && (ren ^ wen);
    assign req_conflict = (state == IDLE) && ren && wen;

    // With no wait states the live request is performed on its sampling
    // edge; otherwise the latched request is performed when cnt runs out.
    // NOTE: every output of an always_comb gets a default first, so no path
    // can leave one unassigned and infer a latch.
    always_comb begin
        acc_fire  = 1'b0;
        acc_write = 1'b0;
        acc_addr  = '0;
        acc_data  = '0;
        if (WAIT_CYCLES == 0) begin
            acc_fire  = req_valid;
            acc_write = wen;
            acc_addr  = addr_out;
            acc_data  = data_out;
        end else begin
            acc_fire  = (state == WAIT) && (cnt == 4'd0);
            acc_write = lat_write;
            acc_addr  = lat_addr;
            acc_data  = lat_data;
        end
    end

    // Upper address bits are dropped for indexing, which mirrors the array.
    assign acc_idx    = acc_addr[MEM_AW-1:0];
    assign acc_in_rom = (acc_addr >= ROM_START);

    // Reset wins on the same edge, so an aborted access never reaches the
    // array.
    assign mem_we = rst && acc_fire && acc_write && !acc_in_rom;

    assign rdy = (state == IDLE);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[acc_idx] <= acc_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            lat_addr    <= '0;
            lat_data    <= '0;
            lat_write   <= 1'b0;
            data_in     <= '0;
            rd_cnt      <= '0;
            wr_cnt      <= '0;
            wr_drop_cnt <= '0;
            err         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_conflict) begin
                        err <= 1'b1;
                    end else if (req_valid) begin
                        lat_addr  <= addr_out;
                        lat_data  <= data_out;
                        lat_write <= wen;
                        if (WAIT_CYCLES != 0) begin
                            state <= WAIT;
                            cnt   <= 4'(WAIT_M1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Read data only moves on reads; writes leave data_in alone.
            if (acc_fire) begin
                if (!acc_write) begin
                    data_in <= mem[acc_idx];
                    rd_cnt  <= rd_cnt + CNT_W'(1);
                end else if (acc_in_rom) begin
                    wr_drop_cnt <= wr_drop_cnt + CNT_W'(1);
                end else begin
                    wr_cnt <= wr_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_bus_mem.sv
// ---------------------------------------------------------------------------
// tb_cpu_bus_mem
//
// Two responders side by side: u_dut0 with no wait states and narrow 4-bit
// counters (so wrap-around is reached quickly), u_dut1 with three wait
// states and 16-bit counters. Both protect addresses at or above 0xC000.
// A reference model keeps a flat array indexed by address modulo the depth
// plus running counts, and is updated once per completed bus operation.
// ---------------------------------------------------------------------------
module tb_cpu_bus_mem;

    localparam int DEPTH = 2048;
    localparam logic [15:0] ROM_BASE = 16'hC000;

    logic        clk;
    logic        rst_v  [2];
    logic        ren_v  [2];
    logic        wen_v  [2];
    logic [15:0] addr_v [2];
    logic [7:0]  wdat_v [2];
    logic [7:0]  dout_v [2];
    logic        rdy_v  [2];
    logic        err_v  [2];

    logic [3:0]  rd0, wr0, dr0;
    logic [15:0] rd1, wr1, dr1;
    logic [15:0] obs_rd [2];
    logic [15:0] obs_wr [2];
    logic [15:0] obs_dr [2];

    assign obs_rd[0] = {12'd0, rd0};
    assign obs_wr[0] = {12'd0, wr0};
    assign obs_dr[0] = {12'd0, dr0};
    assign obs_rd[1] = rd1;
    assign obs_wr[1] = wr1;
    assign obs_dr[1] = dr1;

    cpu_bus_mem #(
        .ADDR_W(16), .DATA_W(8), .MEM_AW(11),
        .WAIT_CYCLES(0), .ROM_START(16'hC000), .CNT_W(4)
    ) u_dut0 (
        .clk(clk), .rst(rst_v[0]),
        .addr_out(addr_v[0]), .data_out(wdat_v[0]),
        .ren(ren_v[0]), .wen(wen_v[0]),
        .data_in(dout_v[0]), .rdy(rdy_v[0]),
        .rd_cnt(rd0), .wr_cnt(wr0), .wr_drop_cnt(dr0), .err(err_v[0])
    );

    cpu_bus_mem #(
        .ADDR_W(16), .DATA_W(8), .MEM_AW(11),
        .WAIT_CYCLES(3), .ROM_START(16'hC000), .CNT_W(16)
    ) u_dut1 (
        .clk(clk), .rst(rst_v[1]),
        .addr_out(addr_v[1]), .data_out(wdat_v[1]),
        .ren(ren_v[1]), .wen(wen_v[1]),
        .data_in(dout_v[1]), .rdy(rdy_v[1]),
        .rd_cnt(rd1), .wr_cnt(wr1), .wr_drop_cnt(dr1), .err(err_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int unsigned wait_of  [2] = '{0, 3};
    int unsigned mask_of  [2] = '{32'hF, 32'hFFFF};
    logic [7:0]  m_mem    [2][DEPTH];
    bit          m_valid  [2][DEPTH];
    int unsigned m_rd     [2];
    int unsigned m_wr     [2];
    int unsigned m_drop   [2];
    bit          m_err    [2];
    logic [7:0]  m_dout   [2];
    bit          m_known  [2];

    int total = 0;
    int bad   = 0;

    // op: 0 = read, 1 = write, 2 = ren and wen together
    localparam int OP_RD = 0;
    localparam int OP_WR = 1;
    localparam int OP_BOTH = 2;

    task automatic model_reset(input int k);
        m_rd[k]    = 0;
        m_wr[k]    = 0;
        m_drop[k]  = 0;
        m_err[k]   = 1'b0;
        m_dout[k]  = 8'h00;
        m_known[k] = 1'b1;
    endtask

    task automatic model_apply(input int k, input int op,
                               input logic [15:0] a, input logic [7:0] d);
        int idx;
        idx = int'(a) % DEPTH;
        if (op == OP_RD) begin
            m_rd[k]++;
            m_dout[k]  = m_mem[k][idx];
            m_known[k] = m_valid[k][idx];
        end else if (op == OP_WR) begin
            if (a >= ROM_BASE) begin
                m_drop[k]++;
            end else begin
                m_wr[k]++;
                m_mem[k][idx]   = d;
                m_valid[k][idx] = 1'b1;
            end
        end else begin
            m_err[k] = 1'b1;
        end
    endtask

    // Entered at a falling edge. Presents one request, then counts the
    // falling edges at which rdy is low (driving junk on the bus meanwhile)
    // and returns the number of stalled cycles and the read data seen.
    task automatic do_access(input int k, input int op,
                             input logic [15:0] a, input logic [7:0] d,
                             output int stall, output logic [7:0] rdata);
        ren_v[k]  = (op != OP_WR);
        wen_v[k]  = (op != OP_RD);
        addr_v[k] = a;
        wdat_v[k] = d;
        @(posedge clk);
        @(negedge clk);
        stall = 0;
        while (rdy_v[k] === 1'b0 && stall < 32) begin
            stall++;
            ren_v[k]  = 1'($urandom);
            wen_v[k]  = 1'($urandom);
            addr_v[k] = 16'($urandom);
            wdat_v[k] = 8'($urandom);
            @(negedge clk);
        end
        ren_v[k] = 1'b0;
        wen_v[k] = 1'b0;
        rdata    = dout_v[k];
    endtask

    // One bus operation followed by comparison of every output with the model.
    task automatic run_op(input int k, input int op,
                          input logic [15:0] a, input logic [7:0] d,
                          output int st, output logic [7:0] rd);
        int exp_st;
        do_access(k, op, a, d, st, rd);
        model_apply(k, op, a, d);
        exp_st = (op == OP_BOTH) ? 0 : int'(wait_of[k]);
        total++;
        if (st !== exp_st) begin
            bad++;
            $display("FAIL stall_cycles k=%0d op=%0d addr=%h got=%0d exp=%0d", k, op, a, st, exp_st);
        end
        if (m_known[k]) begin
            total++;
            if (rd !== m_dout[k]) begin
                bad++;
                $display("FAIL data_in k=%0d op=%0d addr=%h got=%h exp=%h", k, op, a, rd, m_dout[k]);
            end
        end
        total++;
        if (obs_rd[k] !== 16'(m_rd[k] & mask_of[k])) begin
            bad++;
            $display("FAIL rd_cnt k=%0d got=%0d exp=%0d", k, obs_rd[k], m_rd[k] & mask_of[k]);
        end
        total++;
        if (obs_wr[k] !== 16'(m_wr[k] & mask_of[k])) begin
            bad++;
            $display("FAIL wr_cnt k=%0d got=%0d exp=%0d", k, obs_wr[k], m_wr[k] & mask_of[k]);
        end
        total++;
        if (obs_dr[k] !== 16'(m_drop[k] & mask_of[k])) begin
            bad++;
            $display("FAIL wr_drop_cnt k=%0d got=%0d exp=%0d", k, obs_dr[k], m_drop[k] & mask_of[k]);
        end
        total++;
        if (err_v[k] !== m_err[k]) begin
            bad++;
            $display("FAIL err k=%0d got=%b exp=%b", k, err_v[k], m_err[k]);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_v[0] = 1'b0;
        rst_v[1] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            model_reset(k);
            total++;
            if (rdy_v[k] !== 1'b1 || dout_v[k] !== 8'h00 || err_v[k] !== 1'b0 ||
                obs_rd[k] !== 16'd0 || obs_wr[k] !== 16'd0 || obs_dr[k] !== 16'd0) begin
                bad++;
                $display("FAIL reset_values k=%0d got rdy=%b dout=%h err=%b rd=%0d wr=%0d drop=%0d exp 1/00/0/0/0/0",
                         k, rdy_v[k], dout_v[k], err_v[k], obs_rd[k], obs_wr[k], obs_dr[k]);
            end
        end
        rst_v[0] = 1'b1;
        rst_v[1] = 1'b1;
    endtask

    task automatic test_zero_wait();
        int st;
        logic [7:0] rd;
        run_op(0, OP_WR, 16'h0010, 8'hA5, st, rd);
        run_op(0, OP_RD, 16'h0010, 8'h00, st, rd);
        total++;
        if (rd !== 8'hA5 || st !== 0 || obs_wr[0] !== 16'd1 || obs_rd[0] !== 16'd1) begin
            bad++;
            $display("FAIL zero_wait_read got data=%h stall=%0d wr=%0d rd=%0d exp data=a5 stall=0 wr=1 rd=1",
                     rd, st, obs_wr[0], obs_rd[0]);
        end
        // 0x0805 and 0x0005 share array index 0x005.
        run_op(0, OP_WR, 16'h0805, 8'h3C, st, rd);
        run_op(0, OP_RD, 16'h0005, 8'h00, st, rd);
        total++;
        if (rd !== 8'h3C) begin
            bad++;
            $display("FAIL mirror_read got=%h exp=3c", rd);
        end
    endtask

    task automatic test_wait_states();
        int st;
        logic [7:0] rd;
        run_op(1, OP_WR, 16'h0040, 8'h5A, st, rd);
        run_op(1, OP_RD, 16'h0040, 8'h00, st, rd);
        total++;
        if (st !== 3 || rd !== 8'h5A || obs_rd[1] !== 16'd1 || obs_wr[1] !== 16'd1) begin
            bad++;
            $display("FAIL wait3_read got stall=%0d data=%h rd=%0d wr=%0d exp stall=3 data=5a rd=1 wr=1",
                     st, rd, obs_rd[1], obs_wr[1]);
        end
    endtask

    task automatic test_rom();
        int st;
        logic [7:0] rd;
        int unsigned drop0, wr0_before;
        for (int k = 0; k < 2; k++) begin
            // 0x07FC mirrors onto the same index as ROM address 0xFFFC.
            run_op(k, OP_WR, 16'h07FC, 8'h77, st, rd);
            drop0      = m_drop[k];
            wr0_before = m_wr[k];
            run_op(k, OP_WR, 16'hFFFC, 8'h00, st, rd);
            run_op(k, OP_RD, 16'hFFFC, 8'h00, st, rd);
            total++;
            if (rd !== 8'h77 || m_drop[k] != drop0 + 1 || m_wr[k] != wr0_before) begin
                bad++;
                $display("FAIL rom_protect k=%0d got data=%h exp=77", k, rd);
            end
        end
    endtask

    task automatic test_error();
        int st;
        logic [7:0] rd;
        for (int k = 0; k < 2; k++) begin
            run_op(k, OP_BOTH, 16'h07FC, 8'hEE, st, rd);
            run_op(k, OP_RD, 16'h07FC, 8'h00, st, rd);
            total++;
            if (err_v[k] !== 1'b1 || rd !== 8'h77) begin
                bad++;
                $display("FAIL error_then_read k=%0d got err=%b data=%h exp err=1 data=77", k, err_v[k], rd);
            end
        end
    endtask

    task automatic test_back_to_back();
        int st;
        logic [7:0] rd;
        logic [15:0] a;
        logic [7:0] d;
        for (int i = 0; i < 8; i++) begin
            a = 16'($urandom_range(0, 16'hBFFF));
            d = 8'($urandom);
            run_op(0, OP_WR, a, d, st, rd);
            run_op(0, OP_RD, a, 8'h00, st, rd);
            total++;
            if (rd !== d) begin
                bad++;
                $display("FAIL read_after_write addr=%h got=%h exp=%h", a, rd, d);
            end
        end
    endtask

    task automatic test_random(input int k, input int n);
        int st, sel, op;
        logic [7:0] rd;
        logic [15:0] a;
        // Seed the small address pool so every later read has a known value.
        for (int i = 0; i < 32; i++) begin
            run_op(k, OP_WR, 16'(i), 8'($urandom), st, rd);
        end
        for (int i = 0; i < n; i++) begin
            sel = int'($urandom_range(0, 99));
            op  = (sel < 45) ? OP_RD : (sel < 92) ? OP_WR : OP_BOTH;
            a   = 16'($urandom_range(0, 31)) | (16'($urandom) & 16'hF800);
            run_op(k, op, a, 8'($urandom), st, rd);
        end
    endtask

    task automatic test_reset_mid_wait();
        int st;
        logic [7:0] rd;
        run_op(1, OP_WR, 16'h0020, 8'h33, st, rd);
        ren_v[1]  = 1'b0;
        wen_v[1]  = 1'b1;
        addr_v[1] = 16'h0020;
        wdat_v[1] = 8'h11;
        @(posedge clk);
        @(negedge clk);
        wen_v[1] = 1'b0;
        total++;
        if (rdy_v[1] !== 1'b0) begin
            bad++;
            $display("FAIL wait_entered got rdy=%b exp=0", rdy_v[1]);
        end
        @(posedge clk);
        @(negedge clk);
        rst_v[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        model_reset(1);
        total++;
        if (rdy_v[1] !== 1'b1 || obs_wr[1] !== 16'd0 || obs_rd[1] !== 16'd0 ||
            dout_v[1] !== 8'h00 || err_v[1] !== 1'b0) begin
            bad++;
            $display("FAIL abort_reset got rdy=%b wr=%0d rd=%0d dout=%h err=%b exp 1/0/0/00/0",
                     rdy_v[1], obs_wr[1], obs_rd[1], dout_v[1], err_v[1]);
        end
        rst_v[1] = 1'b1;
        run_op(1, OP_RD, 16'h0020, 8'h00, st, rd);
        total++;
        if (rd !== 8'h33 || obs_wr[1] !== 16'd0) begin
            bad++;
            $display("FAIL aborted_write got data=%h wr=%0d exp data=33 wr=0", rd, obs_wr[1]);
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst_v[k]  = 1'b0;
            ren_v[k]  = 1'b0;
            wen_v[k]  = 1'b0;
            addr_v[k] = 16'h0000;
            wdat_v[k] = 8'h00;
        end
        @(negedge clk);
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_rom();
        test_error();
        test_back_to_back();
        test_random(0, 150);
        test_random(1, 150);
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
